lane_rr_scheduler: RTL and testbench

- Controller for the 4-lane, 8-bit mux/demux tree (mux L1 4→2, mux L2 2→1, demux L2 1→2, demux L1 2→4).
- Arbitrates round-robin among the four lane requesters, with a bounded burst length per lane.
- Drives the mux-side selectors, and drives demux-side selectors delayed to match the tree's pipeline latency.
- Replaces the free-running selector stimulus, so lane data is routed end-to-end without being dropped.

---
 rtl/lane_rr_scheduler_pkg.sv | 36 +++
 rtl/lane_rr_scheduler_sel_delay_line.sv | 38 +++
 rtl/lane_rr_scheduler.sv | 160 ++++++++++++++++
 tb/tb_lane_rr_scheduler.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/lane_rr_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module  : lane_rr_scheduler_pkg
// Brief   : Shared lane constants, FSM encodings and helpers for the scheduler
// Rev     : 1.0
// ============================================================================
package lane_rr_scheduler_pkg;

   // A lane index doubles as its {selector1, selector0} encoding.
   localparam logic [1:0] LANE0 = 2'b00;
   localparam logic [1:0] LANE1 = 2'b01;
   localparam logic [1:0] LANE2 = 2'b10;
   localparam logic [1:0] LANE3 = 2'b11;

   localparam int BURST_W = 3;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      SERVE = 2'b01,
      STALL = 2'b10
   } state_t;

   function automatic logic [3:0] lane_onehot(input logic [1:0] i_lane);
      logic [3:0] w_oh;
      case (i_lane)
         LANE0:   w_oh = 4'b0001;
         LANE1:   w_oh = 4'b0010;
         LANE2:   w_oh = 4'b0100;
         LANE3:   w_oh = 4'b1000;
         default: w_oh = 4'b0000;
      endcase
      return w_oh;
   endfunction

endpackage
`default_nettype wire

// File: rtl/lane_rr_scheduler_sel_delay_line.sv
`default_nettype none
// ============================================================================
// Module  : sel_delay_line
// Brief   : DEPTH-stage x 3-bit shift register aligning selectors with data
// Rev     : 1.0
// ============================================================================
module sel_delay_line #(
   parameter int DEPTH = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [2:0] i_d,
   output logic [2:0] o_q
);

   logic [DEPTH-1:0][2:0] r_pipe;
   logic [DEPTH-1:0][2:0] w_next;

   generate
      if (DEPTH == 1) begin : g_single
         assign w_next = i_d;
      end else begin : g_multi
         assign w_next = {r_pipe[DEPTH-2:0], i_d};
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pipe <= '0;
      end else begin
         r_pipe <= w_next;
      end
   end

   assign o_q = r_pipe[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/lane_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : lane_rr_scheduler
// Brief   : Round-robin, burst-bounded lane scheduler for the 4-lane mux/demux tree
// Rev     : 1.0
// ============================================================================
module lane_rr_scheduler
   import lane_rr_scheduler_pkg::*;
#(
   parameter int PIPE_LAT  = 2,
   parameter int MAX_BURST = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic       ready,
   input  logic       validIn0,
   input  logic       validIn1,
   input  logic       validIn2,
   input  logic       validIn3,
   output logic       selector0,
   output logic       selector1,
   output logic [3:0] grant,
   output logic       grantValid,
   output logic       demuxSelector0,
   output logic       demuxSelector1,
   output logic       demuxValid,
   output logic       idle
);

   localparam logic [BURST_W-1:0] C_MAX_BURST = BURST_W'(MAX_BURST);
   localparam logic [BURST_W-1:0] C_ONE       = BURST_W'(1);

   state_t             r_state;
   logic [1:0]         r_lane;
   logic [1:0]         r_ptr;
   logic [BURST_W-1:0] r_burst;
   logic [3:0]         r_grant;
   logic               r_gv;
   logic               r_idle;

   logic [3:0]         w_req;
   logic [2:0]         w_idle_pick;
   logic [2:0]         w_rot_pick;
   logic               w_burst_max;
   logic               w_others;
   logic               w_rotate;
   logic [2:0]         w_dly;

   // Returns {found, lane}: first requester at base+k, k ascending; k=0 skipped on request.
   function automatic logic [2:0] f_next_req(input logic [3:0] i_req,
                                             input logic [1:0] i_base,
                                             input logic       i_skip_base);
      logic [2:0] w_res;
      logic [1:0] w_cand;
      w_res = 3'b000;
      for (int k = 3; k >= 0; k--) begin
         w_cand = i_base + 2'(k);
         if (i_req[w_cand] && ((k != 0) || !i_skip_base)) begin
            w_res = {1'b1, w_cand};
         end
      end
      return w_res;
   endfunction

   always_comb begin
      w_req       = {validIn3, validIn2, validIn1, validIn0};
      w_idle_pick = f_next_req(w_req, r_ptr, 1'b0);
      w_rot_pick  = f_next_req(w_req, r_lane, 1'b1);
      w_burst_max = (r_burst == C_MAX_BURST);
      w_others    = |(w_req & ~lane_onehot(r_lane));
      w_rotate    = !w_req[r_lane] || (w_burst_max && w_others);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= IDLE;
         r_lane  <= LANE0;
         r_ptr   <= LANE0;
         r_burst <= '0;
         r_grant <= 4'b0000;
         r_gv    <= 1'b0;
         r_idle  <= 1'b1;
      end else if (!enable) begin
         r_state <= IDLE;
         r_burst <= '0;
         r_grant <= 4'b0000;
         r_gv    <= 1'b0;
         r_idle  <= 1'b1;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_idle_pick[2]) begin
                  r_lane  <= w_idle_pick[1:0];
                  r_state <= ready ? SERVE : STALL;
                  r_gv    <= ready;
                  r_grant <= ready ? lane_onehot(w_idle_pick[1:0]) : 4'b0000;
                  r_burst <= ready ? C_ONE : '0;
                  r_idle  <= 1'b0;
               end
            end
            SERVE, STALL: begin
               if ((r_state == STALL) && !ready) begin
                  // Frozen: selectors and burst hold until downstream frees up.
                  r_gv    <= 1'b0;
                  r_grant <= 4'b0000;
               end else if (w_rotate) begin
                  r_ptr <= r_lane + 2'd1;
                  if (w_rot_pick[2]) begin
                     r_lane  <= w_rot_pick[1:0];
                     r_state <= ready ? SERVE : STALL;
                     r_gv    <= ready;
                     r_grant <= ready ? lane_onehot(w_rot_pick[1:0]) : 4'b0000;
                     r_burst <= ready ? C_ONE : '0;
                  end else begin
                     r_state <= IDLE;
                     r_burst <= '0;
                     r_gv    <= 1'b0;
                     r_grant <= 4'b0000;
                     r_idle  <= 1'b1;
                  end
               end else begin
                  r_state <= ready ? SERVE : STALL;
                  r_gv    <= ready;
                  r_grant <= ready ? lane_onehot(r_lane) : 4'b0000;
                  if (ready && !w_burst_max) begin
                     r_burst <= r_burst + C_ONE;
                  end
               end
            end
            default: begin
               r_state <= IDLE;
               r_gv    <= 1'b0;
               r_grant <= 4'b0000;
               r_idle  <= 1'b1;
            end
         endcase
      end
   end

   sel_delay_line #(
      .DEPTH (PIPE_LAT)
   ) u_sel_delay_line (
      .clk   (clk),
      .rst_n (reset),
      .i_d   ({r_lane, r_gv}),
      .o_q   (w_dly)
   );

   assign selector0      = r_lane[0];
   assign selector1      = r_lane[1];
   assign grant          = r_grant;
   assign grantValid     = r_gv;
   assign idle           = r_idle;
   assign demuxSelector1 = w_dly[2];
   assign demuxSelector0 = w_dly[1];
   assign demuxValid     = w_dly[0];

endmodule
`default_nettype wire

// File: tb/tb_lane_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : tb_lane_rr_scheduler
// Brief   : Scoreboard bench: rule-level model predicts every cycle and every word
// Rev     : 1.0
// ============================================================================
module tb_lane_rr_scheduler;

   localparam int PIPE_LAT  = 2;
   localparam int MAX_BURST = 4;

   logic       clk    = 1'b0;
   logic       reset  = 1'b0;
   logic       enable = 1'b0;
   logic       ready  = 1'b0;
   logic [3:0] vin    = 4'b0000;
   logic       selector0, selector1, grantValid, idle;
   logic       demuxSelector0, demuxSelector1, demuxValid;
   logic [3:0] grant;

   lane_rr_scheduler #(
      .PIPE_LAT  (PIPE_LAT),
      .MAX_BURST (MAX_BURST)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .enable         (enable),
      .ready          (ready),
      .validIn0       (vin[0]),
      .validIn1       (vin[1]),
      .validIn2       (vin[2]),
      .validIn3       (vin[3]),
      .selector0      (selector0),
      .selector1      (selector1),
      .grant          (grant),
      .grantValid     (grantValid),
      .demuxSelector0 (demuxSelector0),
      .demuxSelector1 (demuxSelector1),
      .demuxValid     (demuxValid),
      .idle           (idle)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       gv;
      logic [3:0] grant;
      logic [1:0] sel;
      logic       idle;
      logic       dv;
      logic [1:0] dsel;
   } rec_t;

   rec_t       cyc_q[$];   // expected outputs, one entry per clock
   int         xfer_q[$];  // lanes of granted words not yet delivered at the demux
   logic [2:0] dly_q[$];   // {sel, gv} words travelling through the tree
   int         checks = 0;
   int         passes = 0;
   bit         started = 1'b0;
   int         cyc_no = 0;

   // Reference model: lane owner, stall flag, grants in the current tenure, RR pointer
   int m_lane, m_ptr, m_cnt;
   bit m_busy, m_stall;

   function automatic int next_req(int from, logic [3:0] v, bit include_from);
      for (int k = include_from ? 0 : 1; k < 4; k++) begin
         if (v[(from + k) % 4]) return (from + k) % 4;
      end
      return -1;
   endfunction

   function automatic rec_t reset_rec();
      rec_t r;
      r = '0;
      r.idle = 1'b1;
      return r;
   endfunction

   task automatic model_reset();
      m_lane = 0; m_ptr = 0; m_cnt = 0; m_busy = 0; m_stall = 0;
      dly_q.delete();
      for (int i = 0; i < PIPE_LAT; i++) dly_q.push_back(3'b000);
      xfer_q.delete();
   endtask

   task automatic model_step(input logic rst, input logic en, input logic rdy, input logic [3:0] v);
      rec_t       r;
      bit         gv;
      int         nxt;
      logic [3:0] own;
      logic [2:0] out;
      gv = 1'b0;
      if (!rst) begin
         model_reset();
         cyc_q.push_back(reset_rec());
         return;
      end
      if (!en) begin
         m_busy = 0; m_stall = 0; m_cnt = 0;
      end else if (!m_busy) begin
         nxt = next_req(m_ptr, v, 1'b1);
         if (nxt >= 0) begin
            m_busy = 1; m_lane = nxt; gv = rdy; m_cnt = rdy ? 1 : 0; m_stall = !rdy;
         end
      end else if (m_stall && !rdy) begin
         gv = 1'b0;
      end else begin
         own = 4'b0001 << m_lane;
         if (!v[m_lane] || (m_cnt >= MAX_BURST && (v & ~own) != 4'b0000)) begin
            nxt   = next_req(m_lane, v, 1'b0);
            m_ptr = (m_lane + 1) % 4;
            if (nxt < 0) begin
               m_busy = 0; m_stall = 0; m_cnt = 0;
            end else begin
               m_lane = nxt; gv = rdy; m_cnt = rdy ? 1 : 0; m_stall = !rdy;
            end
         end else begin
            gv = rdy;
            if (rdy && m_cnt < MAX_BURST) m_cnt++;
            m_stall = !rdy;
         end
      end
      r.gv    = gv;
      r.grant = gv ? (4'b0001 << m_lane) : 4'b0000;
      r.sel   = 2'(m_lane);
      r.idle  = !m_busy;
      dly_q.push_back({2'(m_lane), gv});
      out     = dly_q.pop_front();
      r.dsel  = out[2:1];
      r.dv    = out[0];
      if (gv) xfer_q.push_back(m_lane);
      cyc_q.push_back(r);
   endtask

   task automatic tick(input logic rst, input logic en, input logic rdy, input logic [3:0] v);
      #1;
      if (!rst && reset) begin
         // Asynchronous assertion: outputs clear within the current cycle.
         reset = 1'b0;
         model_reset();
         if (cyc_q.size() > 0) cyc_q[cyc_q.size() - 1] = reset_rec();
      end else begin
         reset = rst;
      end
      enable = en; ready = rdy; vin = v;
      @(posedge clk);
      model_step(rst, en, rdy, v);
      started = 1'b1;
   endtask

   // Monitor: one cycle record per clock, one delivered word per demuxValid
   initial begin
      rec_t exp_r, act_r;
      int   l;
      forever begin
         @(negedge clk);
         if (started) begin
            cyc_no++;
            checks++;
            act_r = {grantValid, grant, selector1, selector0, idle,
                     demuxValid, demuxSelector1, demuxSelector0};
            if (cyc_q.size() == 0) begin
               $display("FAIL cycle-record cyc=%0d: no expected entry, actual=%b", cyc_no, act_r);
            end else begin
               exp_r = cyc_q.pop_front();
               if (act_r === exp_r) passes++;
               else $display("FAIL cycle-record cyc=%0d: actual gv,grant,sel,idle,dv,dsel=%b required=%b",
                             cyc_no, act_r, exp_r);
            end
            if (demuxValid === 1'b1) begin
               checks++;
               if (xfer_q.size() == 0) begin
                  $display("FAIL demux-word cyc=%0d: unexpected word on lane %0d",
                           cyc_no, {demuxSelector1, demuxSelector0});
               end else begin
                  l = xfer_q.pop_front();
                  if ({demuxSelector1, demuxSelector0} === 2'(l)) passes++;
                  else $display("FAIL demux-word cyc=%0d: actual lane %0d required lane %0d",
                                cyc_no, {demuxSelector1, demuxSelector0}, l);
               end
            end
         end
      end
   end

   initial begin
      logic [3:0] v;
      logic       r, e, k;
      model_reset();
      // Reset held with every lane requesting
      repeat (3) tick(1'b0, 1'b1, 1'b1, 4'b1111);
      // Four lanes always valid: bursts of MAX_BURST in RR order
      repeat (22) tick(1'b1, 1'b1, 1'b1, 4'b1111);
      // Single lane: no rotation, burst saturates
      repeat (12) tick(1'b1, 1'b1, 1'b1, 4'b0100);
      // Backpressure in the middle of a burst
      repeat (6) tick(1'b1, 1'b1, 1'b1, 4'b1111);
      repeat (3) tick(1'b1, 1'b1, 1'b0, 4'b1111);
      repeat (12) tick(1'b1, 1'b1, 1'b1, 4'b1111);
      // Rotation coinciding with ready=0, then the owner drops while stalled
      repeat (3) tick(1'b1, 1'b1, 1'b1, 4'b0011);
      tick(1'b1, 1'b1, 1'b0, 4'b0011);
      repeat (2) tick(1'b1, 1'b1, 1'b0, 4'b0001);
      repeat (3) tick(1'b1, 1'b1, 1'b1, 4'b0001);
      // Enable low dominates ready and pending requests
      repeat (3) tick(1'b1, 1'b0, 1'b1, 4'b1111);
      tick(1'b1, 1'b1, 1'b0, 4'b1000);
      repeat (4) tick(1'b1, 1'b1, 1'b1, 4'b1000);
      // Reset mid-operation with words in flight, then no spurious deliveries
      repeat (5) tick(1'b1, 1'b1, 1'b1, 4'b0100);
      repeat (2) tick(1'b0, 1'b1, 1'b1, 4'b0100);
      repeat (5) tick(1'b1, 1'b1, 1'b1, 4'b0000);
      // Randomised traffic with sticky requests, backpressure and rare resets
      v = 4'b0000;
      for (int c = 0; c < 800; c++) begin
         for (int i = 0; i < 4; i++) if ($urandom_range(7) == 0) v[i] = ~v[i];
         r = ($urandom_range(199) != 0);
         e = ($urandom_range(24) != 0);
         k = ($urandom_range(4) != 0);
         tick(r, e, k, v);
      end
      // Drain the tree
      repeat (PIPE_LAT + 3) tick(1'b1, 1'b0, 1'b1, 4'b0000);
      @(negedge clk);
      #1;
      checks++;
      if (cyc_q.size() == 0) passes++;
      else $display("FAIL cycle-queue-drain: actual %0d entries left, required 0", cyc_q.size());
      checks++;
      if (xfer_q.size() == 0) passes++;
      else $display("FAIL undelivered-words: actual %0d words left, required 0", xfer_q.size());
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
`default_nettype wire
